// File: rtl/qsys_system_nios2_3_cpu_ocimem_arbiter_if.sv
// Avalon debug-slave and OCI RAM signals seen by the OCI memory arbiter.
// The arbiter takes the slave view; the CPU side and RAM wrapper take the master view.
interface qsys_system_nios2_3_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W-1:0] av_readdata;
  logic              av_waitrequest;
  logic              ram_en;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  av_address, av_read, av_write, av_writedata, ram_rdata,
    output av_readdata, av_waitrequest, ram_en, ram_wren, ram_addr, ram_wdata
  );

  modport master (
    output av_address, av_read, av_write, av_writedata, ram_rdata,
    input  av_readdata, av_waitrequest, ram_en, ram_wren, ram_addr, ram_wdata
  );
endinterface

// File: rtl/qsys_system_nios2_3_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG strobes and the Avalon debug slave.
// Holds the auto-incrementing JTAG address and one pending JTAG operation.
module qsys_system_nios2_3_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  qsys_system_nios2_3_cpu_ocimem_arbiter_if.slave bus,
  output logic [31:0] MonDReg,
  output logic        mon_busy,
  output logic        jtag_overrun
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_J_RD   = 2'd1;
  localparam logic [1:0] S_A_RD   = 2'd2;
  localparam logic [1:0] J_NONE   = 2'd0;
  localparam logic [1:0] J_READ   = 2'd1;
  localparam logic [1:0] J_WRITE  = 2'd2;
  localparam logic       G_AVALON = 1'b0;
  localparam logic       G_JTAG   = 1'b1;

  logic [1:0]        r_state;
  logic [1:0]        r_jpend;
  logic [ADDR_W-1:0] r_jaddr;
  logic [31:0]       r_jwdata;
  logic [31:0]       r_mondreg;
  logic              r_overrun;
  logic              r_last_grant;

  logic       w_jcand;
  logic       w_acand;
  logic       w_grant_j;
  logic       w_grant_a;
  logic       w_strobe;
  logic       w_accept;
  logic [1:0] w_jreq_kind;
  logic       w_unused_jdo;

  assign w_unused_jdo = ^{jdo[37:35], jdo[16:15], jdo[2:0]};

  // Round-robin between the two requesters only when both are present.
  always_comb begin
    w_jcand   = (r_jpend != J_NONE);
    w_acand   = bus.av_read | bus.av_write;
    w_grant_j = (r_state == S_IDLE) && w_jcand && (!w_acand || (r_last_grant == G_AVALON));
    w_grant_a = (r_state == S_IDLE) && w_acand && !w_grant_j;
    w_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // A strobe landing in the cycle the pending op is consumed is not an overrun.
    w_accept  = !w_jcand || w_grant_j;
    if (take_action_ocimem_b)
      w_jreq_kind = J_WRITE;
    else if (take_no_action_ocimem_a || (take_action_ocimem_a && jdo[14]))
      w_jreq_kind = J_READ;
    else
      w_jreq_kind = J_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_jpend      <= J_NONE;
      r_jaddr      <= '0;
      r_mondreg    <= '0;
      r_overrun    <= 1'b0;
      r_last_grant <= G_AVALON;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_j && (r_jpend == J_READ))
            r_state <= S_J_RD;
          else if (w_grant_a && !bus.av_write)
            r_state <= S_A_RD;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_grant_j)
        r_last_grant <= G_JTAG;
      else if (w_grant_a)
        r_last_grant <= G_AVALON;

      if (r_state == S_J_RD)
        r_mondreg <= bus.ram_rdata[31:0];

      if (w_strobe && !w_accept)
        r_overrun <= 1'b1;

      if (w_strobe && w_accept)
        r_jpend <= w_jreq_kind;
      else if (w_grant_j)
        r_jpend <= J_NONE;

      if (take_action_ocimem_a)
        r_jaddr <= jdo[17 +: ADDR_W];
      else if (w_grant_j)
        r_jaddr <= r_jaddr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_strobe && w_accept && take_action_ocimem_b)
      r_jwdata <= jdo[34:3];
  end

  always_comb begin
    bus.ram_en         = 1'b0;
    bus.ram_wren       = 1'b0;
    bus.ram_addr       = '0;
    bus.ram_wdata      = '0;
    bus.av_waitrequest = 1'b1;
    bus.av_readdata    = '0;
    if (w_grant_j) begin
      bus.ram_en    = 1'b1;
      bus.ram_wren  = (r_jpend == J_WRITE);
      bus.ram_addr  = r_jaddr;
      bus.ram_wdata = DATA_W'(r_jwdata);
    end else if (w_grant_a) begin
      bus.ram_en         = 1'b1;
      bus.ram_wren       = bus.av_write;
      bus.ram_addr       = bus.av_address;
      bus.ram_wdata      = bus.av_writedata;
      bus.av_waitrequest = !bus.av_write;
    end else if (r_state == S_A_RD) begin
      bus.av_readdata    = bus.ram_rdata;
      bus.av_waitrequest = 1'b0;
    end
  end

  assign MonDReg      = r_mondreg;
  assign mon_busy     = w_jcand || (r_state == S_J_RD);
  assign jtag_overrun = r_overrun;
endmodule

// File: tb/tb_qsys_system_nios2_3_cpu_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter with a one-cycle-latency RAM model.
module tb_qsys_system_nios2_3_cpu_ocimem_arbiter;
  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        mon_busy;
  logic        jtag_overrun;
  int          checks;
  int          failures;
  logic [31:0] mem [256];

  qsys_system_nios2_3_cpu_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus_if ();

  qsys_system_nios2_3_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .bus                     (bus_if.slave),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.ram_en) begin
      if (bus_if.ram_wren) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      bus_if.ram_rdata <= mem[bus_if.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_off();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo                     = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    bus_if.ram_rdata    = '0;
    bus_if.av_address   = '0;
    bus_if.av_read      = 1'b0;
    bus_if.av_write     = 1'b0;
    bus_if.av_writedata = '0;
    strobes_off();
    reset_n = 1'b0;
    #3;
    chk("rst_ram_en",   {31'd0, bus_if.ram_en}, 32'd0);
    chk("rst_ram_wren", {31'd0, bus_if.ram_wren}, 32'd0);
    chk("rst_waitreq",  {31'd0, bus_if.av_waitrequest}, 32'd1);
    chk("rst_readdata", bus_if.av_readdata, 32'd0);
    chk("rst_mondreg",  MonDReg, 32'd0);
    chk("rst_busy",     {31'd0, mon_busy}, 32'd0);
    chk("rst_overrun",  {31'd0, jtag_overrun}, 32'd0);
    tick();
    reset_n = 1'b1;

    // JTAG address load with read at 0x10
    take_action_ocimem_a = 1'b1;
    jdo[24:17] = 8'h10;
    jdo[14]    = 1'b1;
    tick();
    strobes_off();
    #1;
    chk("t1_en",   {31'd0, bus_if.ram_en}, 32'd1);
    chk("t1_wren", {31'd0, bus_if.ram_wren}, 32'd0);
    chk("t1_addr", {24'd0, bus_if.ram_addr}, 32'h10);
    chk("t1_busy", {31'd0, mon_busy}, 32'd1);
    tick();
    chk("t1_jrd_en",   {31'd0, bus_if.ram_en}, 32'd0);
    chk("t1_jrd_busy", {31'd0, mon_busy}, 32'd1);
    tick();
    chk("t1_mondreg", MonDReg, 32'hC0DE0010);
    chk("t1_idle_busy", {31'd0, mon_busy}, 32'd0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    strobes_off();
    #1;
    chk("t1_incr_addr", {24'd0, bus_if.ram_addr}, 32'h11);
    tick();
    tick();
    chk("t1_mondreg2", MonDReg, 32'hC0DE0011);

    // JTAG write at 0xFF, then address wrap
    take_action_ocimem_a = 1'b1;
    jdo[24:17] = 8'hFF;
    tick();
    strobes_off();
    #1;
    chk("t2_noread_en", {31'd0, bus_if.ram_en}, 32'd0);
    take_action_ocimem_b = 1'b1;
    jdo[34:3] = 32'hDEADBEEF;
    tick();
    strobes_off();
    #1;
    chk("t2_wren",  {31'd0, bus_if.ram_wren}, 32'd1);
    chk("t2_addr",  {24'd0, bus_if.ram_addr}, 32'hFF);
    chk("t2_wdata", bus_if.ram_wdata, 32'hDEADBEEF);
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick();
    strobes_off();
    #1;
    chk("t2_wrap_addr", {24'd0, bus_if.ram_addr}, 32'h00);
    tick();
    tick();
    chk("t2_mondreg0", MonDReg, 32'hC0DE0000);
    take_action_ocimem_a = 1'b1;
    jdo[24:17] = 8'hFF;
    jdo[14]    = 1'b1;
    tick();
    strobes_off();
    tick();
    tick();
    chk("t2_readback", MonDReg, 32'hDEADBEEF);

    // Avalon read 0x20 and write 0x30 without contention
    bus_if.av_read    = 1'b1;
    bus_if.av_address = 8'h20;
    #1;
    chk("t3_wait1", {31'd0, bus_if.av_waitrequest}, 32'd1);
    chk("t3_addr",  {24'd0, bus_if.ram_addr}, 32'h20);
    tick();
    chk("t3_wait0", {31'd0, bus_if.av_waitrequest}, 32'd0);
    chk("t3_rdata", bus_if.av_readdata, 32'hC0DE0020);
    tick();
    bus_if.av_read = 1'b0;
    #1;
    chk("t3_rdata_idle", bus_if.av_readdata, 32'd0);
    bus_if.av_write     = 1'b1;
    bus_if.av_address   = 8'h30;
    bus_if.av_writedata = 32'h12345678;
    #1;
    chk("t3_wr_wait", {31'd0, bus_if.av_waitrequest}, 32'd0);
    chk("t3_wr_wren", {31'd0, bus_if.ram_wren}, 32'd1);
    tick();
    bus_if.av_write = 1'b0;
    #1;
    chk("t3_mem30", mem[8'h30], 32'h12345678);

    // Back-to-back ties: JTAG first, then Avalon, then JTAG again
    take_action_ocimem_b = 1'b1;
    jdo[34:3] = 32'h11111111;
    tick();
    strobes_off();
    bus_if.av_write      = 1'b1;
    bus_if.av_address    = 8'h40;
    bus_if.av_writedata  = 32'h22222222;
    take_action_ocimem_b = 1'b1;
    jdo[34:3]            = 32'h33333333;
    #1;
    chk("t4_tie1_addr",  {24'd0, bus_if.ram_addr}, 32'h00);
    chk("t4_tie1_wdata", bus_if.ram_wdata, 32'h11111111);
    chk("t4_tie1_wait",  {31'd0, bus_if.av_waitrequest}, 32'd1);
    tick();
    strobes_off();
    #1;
    chk("t4_tie2_addr",  {24'd0, bus_if.ram_addr}, 32'h40);
    chk("t4_tie2_wdata", bus_if.ram_wdata, 32'h22222222);
    chk("t4_tie2_wait",  {31'd0, bus_if.av_waitrequest}, 32'd0);
    tick();
    bus_if.av_write = 1'b0;
    #1;
    chk("t4_j2_addr",  {24'd0, bus_if.ram_addr}, 32'h01);
    chk("t4_j2_wdata", bus_if.ram_wdata, 32'h33333333);
    chk("t4_overrun",  {31'd0, jtag_overrun}, 32'd0);
    tick();

    // Overrun while an Avalon read holds the RAM
    bus_if.av_read          = 1'b1;
    bus_if.av_address       = 8'h50;
    take_no_action_ocimem_a = 1'b1;
    #1;
    chk("t5_av_addr", {24'd0, bus_if.ram_addr}, 32'h50);
    tick();
    #1;
    chk("t5_ard_rdata", bus_if.av_readdata, 32'hC0DE0050);
    chk("t5_ard_en",    {31'd0, bus_if.ram_en}, 32'd0);
    tick();
    strobes_off();
    bus_if.av_read = 1'b0;
    #1;
    chk("t5_overrun", {31'd0, jtag_overrun}, 32'd1);
    chk("t5_j_addr",  {24'd0, bus_if.ram_addr}, 32'h02);
    chk("t5_j_en",    {31'd0, bus_if.ram_en}, 32'd1);
    tick();
    tick();
    chk("t5_mondreg", MonDReg, 32'hC0DE0002);
    chk("t5_no_second_access", {31'd0, bus_if.ram_en}, 32'd0);
    chk("t5_busy", {31'd0, mon_busy}, 32'd0);

    // Reset during J_RD
    take_no_action_ocimem_a = 1'b1;
    tick();
    strobes_off();
    #1;
    chk("t6_addr", {24'd0, bus_if.ram_addr}, 32'h03);
    tick();
    chk("t6_jrd_busy", {31'd0, mon_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_mondreg", MonDReg, 32'd0);
    chk("t6_rst_busy",    {31'd0, mon_busy}, 32'd0);
    chk("t6_rst_overrun", {31'd0, jtag_overrun}, 32'd0);
    chk("t6_rst_en",      {31'd0, bus_if.ram_en}, 32'd0);
    tick();
    reset_n = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    strobes_off();
    #1;
    chk("t6_after_addr", {24'd0, bus_if.ram_addr}, 32'h00);
    tick();
    tick();
    chk("t6_after_mondreg", MonDReg, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
